// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
// The master drives requests (the bench); the slave is the divider itself.
interface seq_divider_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// Results land in dedicated output registers only when the division completes.
module seq_divider #(
   parameter int WIDTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   seq_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state, w_next;
   logic             w_busy, w_done;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_dvd;   // dividend bits shift out the top, quotient bits in the bottom
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_q, r_r;
   logic             r_dbz;

   logic             w_accept, w_zero, w_last, w_ge;
   logic [WIDTH:0]   w_trial, w_diff;
   logic [WIDTH-1:0] w_rem_nxt;

   assign w_accept  = bus.start && (r_state != RUN);
   assign w_zero    = (r_dvs == '0);
   assign w_last    = w_zero || (r_cnt == CW'(1));
   assign w_trial   = {r_rem, r_dvd[WIDTH-1]};
   assign w_diff    = w_trial - {1'b0, r_dvs};
   // r_rem < r_dvs always holds, so a clear top bit of the difference means trial >= divisor
   assign w_ge      = ~w_diff[WIDTH];
   assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         IDLE: if (bus.start) w_next = RUN;
         RUN: begin
            w_busy = 1'b1;
            if (w_last) w_next = DONE;
         end
         DONE: begin
            w_done = 1'b1;
            w_next = bus.start ? RUN : IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_dvd <= '0;
         r_dvs <= '0;
         r_rem <= '0;
         r_q   <= '0;
         r_r   <= '0;
         r_dbz <= 1'b0;
      end else if (w_accept) begin
         r_dvd <= bus.dividend;
         r_dvs <= bus.divisor;
         r_rem <= '0;
         r_cnt <= CW'(WIDTH);
         r_dbz <= 1'b0;
      end else if (r_state == RUN) begin
         if (w_zero) begin
            r_q   <= '1;
            r_r   <= r_dvd;
            r_dbz <= 1'b1;
            r_cnt <= '0;
         end else begin
            r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
               r_q <= {r_dvd[WIDTH-2:0], w_ge};
               r_r <= w_rem_nxt;
            end
         end
      end
   end

   assign bus.busy        = w_busy;
   assign bus.done        = w_done;
   assign bus.quotient    = r_q;
   assign bus.remainder   = r_r;
   assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed bench for seq_divider, checked every cycle against
// an arithmetic model (/ and %) with a cycle-count latency model.
module tb_seq_divider;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_divider_if #(.WIDTH(W)) bus ();
   seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: operation phase, cycles left, and results from / and %
   typedef enum {M_IDLE, M_RUN, M_DONE} mph_t;
   mph_t         ph;
   int           left;
   logic [W-1:0] ma, mb, m_q, m_r;
   logic         m_dbz;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ph = M_IDLE; left = 0; ma = '0; mb = '0;
         m_q = '0; m_r = '0; m_dbz = 1'b0;
      end else if (ph == M_RUN) begin
         left--;
         if (left == 0) begin
            ph = M_DONE;
            if (mb == 0) begin
               m_q = '1; m_r = ma; m_dbz = 1'b1;
            end else begin
               m_q = ma / mb; m_r = ma % mb;
            end
         end
      end else if (bus.start) begin
         ma = bus.dividend; mb = bus.divisor; m_dbz = 1'b0;
         left = (bus.divisor == 0) ? 1 : W;
         ph = M_RUN;
      end else begin
         ph = M_IDLE;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("busy", {31'b0, bus.busy}, {31'b0, ph == M_RUN});
         chk("done", {31'b0, bus.done}, {31'b0, ph == M_DONE});
         chk("quotient", {16'b0, bus.quotient}, {16'b0, m_q});
         chk("remainder", {16'b0, bus.remainder}, {16'b0, m_r});
         chk("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, m_dbz});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
      tick();
      bus.start = 1'b0;
   endtask

   // Called just after the accepting edge (or later with exp_busy<0); counts edges to done.
   task automatic wait_done(input string nm, input int exp_edges, input logic [W-1:0] eq,
                            input logic [W-1:0] er, input logic edbz, input int exp_busy);
      int  bc;
      int  edges;
      bit  seen;
      bc = int'(bus.busy); seen = 1'b0; edges = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (bus.done) begin
            seen = 1'b1; edges = k;
            break;
         end
         bc += int'(bus.busy);
      end
      chk({nm, "_done_seen"}, {31'b0, seen}, 32'd1);
      if (seen) begin
         chk({nm, "_edges"}, edges, exp_edges);
         chk({nm, "_q"}, {16'b0, bus.quotient}, {16'b0, eq});
         chk({nm, "_r"}, {16'b0, bus.remainder}, {16'b0, er});
         chk({nm, "_dbz"}, {31'b0, bus.div_by_zero}, {31'b0, edbz});
         chk({nm, "_model_q"}, {16'b0, m_q}, {16'b0, eq});
         chk({nm, "_model_r"}, {16'b0, m_r}, {16'b0, er});
         if (exp_busy >= 0) chk({nm, "_busy_cycles"}, bc, exp_busy);
      end
   endtask

   logic [W-1:0] ra, rb;

   initial begin
      rst = 1'b1; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_done", {31'b0, bus.done}, 32'd0);
      chk("rst_q", {16'b0, bus.quotient}, 32'd0);
      chk("rst_r", {16'b0, bus.remainder}, 32'd0);
      chk("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
      rst = 1'b0;
      tick();

      launch(16'd100, 16'd7);
      wait_done("basic", 16, 16'd14, 16'd2, 1'b0, 16);
      tick();
      launch(16'hFFFF, 16'd1);
      wait_done("ffff_1", 16, 16'hFFFF, 16'd0, 1'b0, 16);
      launch(16'd3, 16'd10);
      wait_done("3_10", 16, 16'd0, 16'd3, 1'b0, 16);
      launch(16'hFFFF, 16'hFFFF);
      wait_done("ffff_ffff", 16, 16'd1, 16'd0, 1'b0, 16);
      launch(16'h1234, 16'd0);
      wait_done("zero_div", 1, 16'hFFFF, 16'h1234, 1'b1, 1);

      // start during RUN must be ignored
      launch(16'd50, 16'd5);
      repeat (4) tick();
      bus.start = 1'b1; bus.dividend = 16'd9; bus.divisor = 16'd2;
      tick();
      bus.start = 1'b0;
      wait_done("start_in_run", 11, 16'd10, 16'd0, 1'b0, -1);
      tick();

      // back-to-back: start high while in DONE
      launch(16'd100, 16'd7);
      wait_done("b2b_first", 16, 16'd14, 16'd2, 1'b0, 16);
      launch(16'd81, 16'd9);
      chk("b2b_busy", {31'b0, bus.busy}, 32'd1);
      chk("b2b_hold_q", {16'b0, bus.quotient}, 32'd14);
      chk("b2b_hold_r", {16'b0, bus.remainder}, 32'd2);
      wait_done("b2b_second", 16, 16'd9, 16'd0, 1'b0, 16);
      tick();

      // reset mid-operation
      launch(16'd200, 16'd3);
      repeat (8) tick();
      rst = 1'b1;
      #1;
      chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
      chk("midrst_done", {31'b0, bus.done}, 32'd0);
      chk("midrst_q", {16'b0, bus.quotient}, 32'd0);
      chk("midrst_r", {16'b0, bus.remainder}, 32'd0);
      chk("midrst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("midrst_no_done", {31'b0, bus.done}, 32'd0);
      end
      launch(16'd200, 16'd3);
      wait_done("after_rst", 16, 16'd66, 16'd2, 1'b0, 16);

      // random phase: free-running starts, back-to-back, start in RUN, rare async resets
      for (int c = 0; c < 40000; c++) begin
         case ($urandom % 4)
            0: ra = W'($urandom % 16);
            1: ra = 16'hFFFF;
            default: ra = W'($urandom);
         endcase
         case ($urandom % 8)
            0: rb = '0;
            1: rb = 16'd1;
            2: rb = W'($urandom % 16);
            3: rb = 16'hFFFF;
            default: rb = W'($urandom);
         endcase
         bus.start = ($urandom % 4 == 0);
         bus.dividend = ra;
         bus.divisor = rb;
         if ($urandom % 1000 == 0) begin
            #2 rst = 1'b1;
            #1 rst = 1'b0;
         end
         tick();
      end
      bus.start = 1'b0;
      repeat (20) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
